// File: rtl/mux_field_scan_if.sv
// Request and output-beat bundle for mux_field_scan: the wide field vector,
// the request channel (valid/ready) and the registered beat channel (valid/ready).
interface mux_field_scan_if #(
    parameter int W = 4,
    parameter int N = 256
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  in_data;
    logic            req_valid;
    logic            req_ready;
    logic            req_mode;
    logic [SELW-1:0] req_sel;
    logic [SELW-1:0] req_len;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_idx;
    logic            out_last;
    logic            out_wrap;
    logic            busy;

    modport master (
        output in_data, req_valid, req_mode, req_sel, req_len, out_ready,
        input  req_ready, out_valid, out_data, out_idx, out_last, out_wrap, busy
    );

    modport slave (
        input  in_data, req_valid, req_mode, req_sel, req_len, out_ready,
        output req_ready, out_valid, out_data, out_idx, out_last, out_wrap, busy
    );
endinterface

// File: rtl/mux_field_scan.sv
// Registered W-bit field selector over an N-field vector: single-select or a
// wrapping scan of consecutive fields, emitted through a one-deep valid/ready stage.
module mux_field_scan #(
    parameter int W = 4,
    parameter int N = 256
) (
    input  logic             clk,
    input  logic             resetn,
    mux_field_scan_if.slave  bus
);
    localparam int SELW = $clog2(N);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic [SELW-1:0] rem_q, rem_d;
    logic            wrapf_q, wrapf_d;

    logic            vld_p1;
    logic [W-1:0]    data_p1;
    logic [SELW-1:0] idx_p1;
    logic            last_p1;
    logic            wrap_p1;

    logic            adv;
    logic            load;
    logic [SELW-1:0] ld_idx;
    logic            ld_last;
    logic            ld_wrap;

    // Out-of-range indices (non-power-of-two N) read as zero.
    function automatic logic [W-1:0] field_at(input logic [N*W-1:0] v, input logic [SELW-1:0] i);
        if (32'(i) >= N) return '0;
        return v[32'(i)*W +: W];
    endfunction

    function automatic logic is_top(input logic [SELW-1:0] i);
        return (32'(i) == N - 1);
    endfunction

    // Explicit compare so N need not be a power of two; out-of-range also restarts at 0.
    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] i);
        if (32'(i) >= N - 1) return '0;
        return i + SELW'(1);
    endfunction

    assign adv           = !vld_p1 || bus.out_ready;
    assign bus.req_ready = resetn && (state_q == IDLE) && adv;
    assign bus.busy      = (state_q == SCAN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        wrapf_d = wrapf_q;
        load    = 1'b0;
        ld_idx  = '0;
        ld_last = 1'b0;
        ld_wrap = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && adv) begin
                    load   = 1'b1;
                    ld_idx = bus.req_sel;
                    if (bus.req_mode && (bus.req_len != '0)) begin
                        state_d = SCAN;
                        idx_d   = next_idx(bus.req_sel);
                        wrapf_d = is_top(bus.req_sel);
                        rem_d   = bus.req_len - SELW'(1);
                    end else begin
                        ld_last = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_idx  = idx_q;
                    ld_wrap = wrapf_q;
                    ld_last = (rem_q == '0);
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = next_idx(idx_q);
                        wrapf_d = is_top(idx_q);
                        rem_d   = rem_q - SELW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: output beat register, field sampled live at the load edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            wrapf_q <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
            wrap_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            wrapf_q <= wrapf_d;
            if (load) begin
                vld_p1  <= 1'b1;
                data_p1 <= field_at(bus.in_data, ld_idx);
                idx_p1  <= ld_idx;
                last_p1 <= ld_last;
                wrap_p1 <= ld_wrap;
            end else if (bus.out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_idx   = idx_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_wrap  = wrap_p1;
endmodule

// File: tb/tb_mux_field_scan.sv
// Bench for mux_field_scan: directed steps plus randomized requests checked
// against an index-arithmetic reference model (N=256/W=4 and N=5/W=8 instances).
module tb_mux_field_scan;
    localparam int BW = 4;
    localparam int BN = 256;
    localparam int BS = 8;
    localparam int SW = 8;
    localparam int SN = 5;
    localparam int SS = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mux_field_scan_if #(.W(BW), .N(BN)) bb ();
    mux_field_scan_if #(.W(SW), .N(SN)) sb ();

    mux_field_scan #(.W(BW), .N(BN)) dut_big   (.clk(clk), .resetn(resetn), .bus(bb));
    mux_field_scan #(.W(SW), .N(SN)) dut_small (.clk(clk), .resetn(resetn), .bus(sb));

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          last;
        bit          wrap;
    } beat_t;

    int          total = 0;
    int          bad   = 0;
    logic [BW-1:0] bf [BN];
    logic [SW-1:0] sf [SN];
    beat_t       exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_big();
        for (int k = 0; k < BN; k++) bb.in_data[k*BW +: BW] = bf[k];
    endtask

    task automatic pack_small();
        for (int k = 0; k < SN; k++) sb.in_data[k*SW +: SW] = sf[k];
    endtask

    // Reference: beat k of a request shows field (sel+k) mod N; wrap marks index 0 after the first beat.
    task automatic build_big(input bit mode, input int sel, input int len);
        int n;
        beat_t b;
        n = (mode && len > 0) ? len + 1 : 1;
        for (int k = 0; k < n; k++) begin
            b.idx  = (sel + k) % BN;
            b.data = 32'(bf[b.idx]);
            b.last = (k == n - 1);
            b.wrap = (k > 0) && (b.idx == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_big(input bit mode, input int sel, input int len, input bit full);
        bit    acc;
        int    guard;
        beat_t b;
        build_big(mode, sel, len);
        acc = 1'b0;
        guard = 0;
        while ((!acc || exp_q.size() > 0) && guard < 5000) begin
            @(negedge clk);
            bb.req_valid = !acc;
            bb.req_mode  = mode;
            bb.req_sel   = BS'(sel);
            bb.req_len   = BS'(len);
            bb.out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (full && !acc) chk("ready_idle", 32'(bb.req_ready), 32'(1));
            if (full && acc && exp_q.size() > 0) begin
                chk("throughput", 32'(bb.out_valid), 32'(1));
                chk("busy", 32'(bb.busy), 32'(!exp_q[0].last));
                chk("ready_scan", 32'(bb.req_ready), 32'(exp_q[0].last));
            end
            if (bb.out_valid && bb.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(1), 32'(0));
                end else begin
                    b = exp_q.pop_front();
                    chk("idx", 32'(bb.out_idx), 32'(b.idx));
                    chk("data", 32'(bb.out_data), b.data);
                    chk("last", 32'(bb.out_last), 32'(b.last));
                    chk("wrap", 32'(bb.out_wrap), 32'(b.wrap));
                end
            end
            if (!acc && bb.req_ready) acc = 1'b1;
            guard++;
        end
        if (guard >= 5000) begin
            chk("timeout", 32'(0), 32'(1));
            exp_q.delete();
        end
        bb.req_valid = 1'b0;
    endtask

    initial begin
        int seq_bp [3];
        int seq_sm [5];
        int seen;
        bit m;
        int s;
        int l;

        for (int k = 0; k < BN; k++) bf[k] = BW'(k);
        for (int k = 0; k < SN; k++) sf[k] = SW'($urandom);
        pack_big();
        pack_small();
        bb.req_valid = 1'b1;
        bb.req_mode  = 1'b0;
        bb.req_sel   = '0;
        bb.req_len   = '0;
        bb.out_ready = 1'b1;
        sb.req_valid = 1'b0;
        sb.req_mode  = 1'b0;
        sb.req_sel   = '0;
        sb.req_len   = '0;
        sb.out_ready = 1'b1;
        resetn = 1'b0;

        // Reset with a request pending
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bb.req_ready), 32'(0));
        chk("rst_valid", 32'(bb.out_valid), 32'(0));
        chk("rst_data", 32'(bb.out_data), 32'(0));
        chk("rst_idx", 32'(bb.out_idx), 32'(0));
        chk("rst_last", 32'(bb.out_last), 32'(0));
        chk("rst_wrap", 32'(bb.out_wrap), 32'(0));
        chk("rst_busy", 32'(bb.busy), 32'(0));
        @(negedge clk);
        bb.req_valid = 1'b0;
        resetn = 1'b1;
        #1;
        chk("rel_ready", 32'(bb.req_ready), 32'(1));

        // Single select of field 42
        run_big(1'b0, 42, 0, 1'b1);

        // Back-to-back single selects with no bubble
        @(negedge clk);
        bb.req_valid = 1'b1; bb.req_mode = 1'b0; bb.req_sel = 8'd1; bb.out_ready = 1'b1;
        #1;
        chk("b2b_ready0", 32'(bb.req_ready), 32'(1));
        @(negedge clk);
        bb.req_sel = 8'd2;
        #1;
        chk("b2b_ready1", 32'(bb.req_ready), 32'(1));
        chk("b2b_idx1", 32'(bb.out_idx), 32'(1));
        chk("b2b_last1", 32'(bb.out_last), 32'(1));
        @(negedge clk);
        bb.req_valid = 1'b0;
        #1;
        chk("b2b_valid2", 32'(bb.out_valid), 32'(1));
        chk("b2b_idx2", 32'(bb.out_idx), 32'(2));
        @(negedge clk);
        #1;
        chk("b2b_drain", 32'(bb.out_valid), 32'(0));

        // Wrapping scan 254,255,0,1
        run_big(1'b1, 254, 3, 1'b1);

        // Backpressure: hold the first beat for three cycles
        seq_bp = '{10, 11, 12};
        @(negedge clk);
        bb.req_valid = 1'b1; bb.req_mode = 1'b1; bb.req_sel = 8'd10; bb.req_len = 8'd2;
        bb.out_ready = 1'b0;
        #1;
        chk("bp_accept", 32'(bb.req_ready), 32'(1));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bb.req_valid = 1'b0;
            bb.out_ready = 1'b0;
            #1;
            chk("bp_hold_valid", 32'(bb.out_valid), 32'(1));
            chk("bp_hold_idx", 32'(bb.out_idx), 32'(10));
            chk("bp_hold_data", 32'(bb.out_data), 32'(bf[10]));
            chk("bp_hold_ready", 32'(bb.req_ready), 32'(0));
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bb.out_ready = 1'b1;
            #1;
            chk("bp_seq_idx", 32'(bb.out_idx), 32'(seq_bp[j]));
            chk("bp_seq_data", 32'(bb.out_data), 32'(bf[seq_bp[j]]));
            chk("bp_seq_last", 32'(bb.out_last), 32'(j == 2));
            chk("bp_seq_ready", 32'(bb.req_ready), 32'(j == 2));
        end
        @(negedge clk);
        #1;
        chk("bp_drain", 32'(bb.out_valid), 32'(0));

        // Reset in the middle of a long scan
        @(negedge clk);
        bb.req_valid = 1'b1; bb.req_mode = 1'b1; bb.req_sel = 8'd0; bb.req_len = 8'd100;
        bb.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bb.req_valid = 1'b0;
            #1;
            chk("mid_idx", 32'(bb.out_idx), 32'(j));
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", 32'(bb.out_valid), 32'(0));
        chk("mid_rst_busy", 32'(bb.busy), 32'(0));
        resetn = 1'b1;
        run_big(1'b0, 7, 0, 1'b1);

        // N=5 instance: full wrapping scan and an out-of-range select
        seq_sm = '{3, 4, 0, 1, 2};
        seen = 0;
        @(negedge clk);
        sb.req_valid = 1'b1; sb.req_mode = 1'b1; sb.req_sel = 3'd3; sb.req_len = 3'd4;
        sb.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            sb.req_valid = 1'b0;
            #1;
            chk("sm_valid", 32'(sb.out_valid), 32'(1));
            chk("sm_idx", 32'(sb.out_idx), 32'(seq_sm[j]));
            chk("sm_data", 32'(sb.out_data), 32'(sf[seq_sm[j]]));
            chk("sm_wrap", 32'(sb.out_wrap), 32'(j > 0 && seq_sm[j] == 0));
            chk("sm_last", 32'(sb.out_last), 32'(j == 4));
            if (32'(sb.out_idx) < SN) seen = seen | (1 << sb.out_idx);
        end
        chk("sm_coverage", 32'(seen), 32'(5'h1F));
        @(negedge clk);
        sb.req_valid = 1'b1; sb.req_mode = 1'b0; sb.req_sel = 3'd6; sb.req_len = 3'd0;
        @(negedge clk);
        sb.req_valid = 1'b0;
        #1;
        chk("sm_oor_valid", 32'(sb.out_valid), 32'(1));
        chk("sm_oor_data", 32'(sb.out_data), 32'(0));
        chk("sm_oor_idx", 32'(sb.out_idx), 32'(6));
        chk("sm_oor_last", 32'(sb.out_last), 32'(1));

        // Randomized requests with random consumer stalls
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < BN; k++) bf[k] = BW'($urandom);
            pack_big();
            m = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, BN - 1));
            l = (r % 10 == 3) ? BN - 1 : int'($urandom_range(0, 12));
            run_big(m, s, l, (r % 4 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_field_scan.md
Name: mux_field_scan

Overview:
- Parametrised, registered successor to the team's combinational wide field mux.
- Selects one W-bit field out of an N-field packed vector, then does one of two things:
  - single-select mode: returns one field per request;
  - scan mode: streams a run of consecutive fields starting at a base index, wrapping modulo N.
- Output is a one-deep registered stage with a valid/ready handshake.
- Sits between wide status/lookup vectors and narrow serial consumers.

Parameters:
- W, 4, bits per field (≥1)
- N, 256, number of fields (≥2; need not be a power of two)
- SELW, $clog2(N), index width; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- in_data  input  N*W  packed fields; field k = in_data[k*W +: W]
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_mode  input  1  0 = single select, 1 = scan
- req_sel  input  SELW  start index (must be < N)
- req_len  input  SELW  scan beats minus 1 (ignored in mode 0)
- out_valid  output  1  out_* registers hold a beat
- out_ready  input  1  consumer accepts beat
- out_data  output  W  selected field
- out_idx  output  SELW  index of field in out_data
- out_last  output  1  final beat of the request
- out_wrap  output  1  this beat's index wrapped N-1 → 0 within the scan
- busy  output  1  state == SCAN

Behaviour:
- Reset (resetn low at a rising edge): state = IDLE; out_valid, out_data, out_idx, out_last, out_wrap, busy all 0; internal index/remaining counters 0.
  - Reset mid-scan abandons the scan immediately; the pending output beat is dropped.
- Output register rule:
  - adv = !out_valid | out_ready.
  - A new beat loads only when adv.
  - If out_valid & out_ready with no new load, out_valid clears next cycle.
  - out_* hold stable while out_valid & !out_ready.
- Field sampling: the field is sampled from in_data at the load edge (live; the input is not captured at request time). Latency: request/beat accept → out_valid one cycle later.
- req_ready = (state == IDLE) & adv (combinational). Full throughput: one beat per cycle when out_ready is held high.
- IDLE, on request accept:
  - mode 0: load field req_sel; out_idx = req_sel; out_last = 1; out_wrap = 0; stay IDLE.
  - mode 1, req_len == 0: same as mode 0.
  - mode 1, req_len > 0: load field req_sel with out_last = 0, out_wrap = 0. Next index = (req_sel == N-1) ? 0 : req_sel+1. remaining = req_len - 1. Go to SCAN.
- SCAN, on each cycle with adv:
  - load field at current index; out_idx = index;
  - out_wrap = 1 iff this index was reached by wrapping from N-1;
  - out_last = (remaining == 0).
  - If last, go to IDLE; else advance the index modulo N (explicit compare with N-1, not a power-of-two mask) and decrement remaining.
  - If !adv, hold index, remaining and state.
- Scan length: req_len = N-1 gives N beats covering every field exactly once. req_len ≥ N is not supported (the request is still processed, with wraps continuing).
- Back-to-back requests:
  - IDLE may accept a new request in the same cycle the previous last beat is consumed (adv true), with no bubble.
  - A request cannot be accepted in the cycle SCAN emits its last beat; it is accepted the next cycle.
- req_sel ≥ N (only possible when N is not a power of two): out_data = 0, out_idx = req_sel; scan index is forced to 0 on the next step.
- No combinational path from out_ready to out_data/out_valid. req_ready does depend on out_ready.

Test Plan:
- Reset then idle: hold resetn=0 for 2 cycles with req_valid=1 → req_ready=0 during reset, all outputs 0; after release, req_ready=1.
- Single select, W=4, N=256, in_data[k*4+:4]=k[3:0]: mode 0, sel=8'h2A → next cycle out_valid=1, out_data=4'hA, out_idx=42, out_last=1, out_wrap=0.
- Wrapping scan: mode 1, sel=254, len=3, out_ready=1 → beats with idx 254, 255, 0, 1 on consecutive cycles; out_wrap=1 only on idx 0; out_last only on idx 1; busy=1 from cycle after accept until the last beat loads.
- Backpressure: scan sel=10, len=2; drop out_ready for 3 cycles after the first beat → out_data/out_idx held stable at idx 10; no beat lost or duplicated; sequence 10, 11, 12; req_ready=0 throughout.
- Non-power-of-two, N=5, W=8: mode 1, sel=3, len=4 → idx 3, 4, 0, 1, 2; wrap flagged on 0; all 5 fields each seen once.
- Reset mid-scan: sel=0, len=100; assert resetn=0 after 5 beats → out_valid=0 and busy=0 the following cycle; a fresh mode 0 sel=7 request then returns field 7 with out_last=1.
